ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Round-robin AHB bus arbiter and address/data multiplexer for NUM_MASTERS bus masters sharing one slave side (ROM, data memory, result memory).
- Instruction fetch/execute FSMs and a future DMA each request the bus. The arbiter grants one master at a time and routes its address-phase and data-phase signals to the slaves.
- Honours bursts, locked transfers and a fairness hold limit.

Parameters:
- NUM_MASTERS, 3: number of requesting masters (2..8).
- DEFAULT_MASTER, 0: master parked on the bus when nobody requests.
- MAX_HOLD, 4: completed NONSEQ single transfers an owner may issue before it must yield to a waiting requester.
- MW, $clog2(NUM_MASTERS): master index width (derived).

Ports:
- HCLK  in  1  bus clock
- HRESTn  in  1  asynchronous active-low reset
- HREADY  in  1  slave ready; transfer boundary when high
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK_M  in  NUM_MASTERS  per-master lock request
- HTRANS_M  in  2*NUM_MASTERS  per-master HTRANS
- HADDR_M  in  32*NUM_MASTERS  per-master HADDR
- HWRITE_M  in  NUM_MASTERS  per-master HWRITE
- HSIZE_M  in  3*NUM_MASTERS  per-master HSIZE
- HBURST_M  in  NUM_MASTERS  per-master HBURST (0 single, 1 INCR)
- HWDATA_M  in  32*NUM_MASTERS  per-master HWDATA
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  MW  index of address-phase owner, registered
- HMASTLOCK  out  1  locked transfer in progress
- HADDR, HTRANS, HWRITE, HSIZE, HBURST  out  32/2/1/3/1  muxed address phase
- HWDATA  out  32  muxed data phase

Behaviour:
- Reset (HRESTn low, async):
  - HGRANT = one-hot DEFAULT_MASTER; HMASTER = DEFAULT_MASTER; data-phase owner DMASTER = DEFAULT_MASTER.
  - hold counter = 0; state = PARK; HMASTLOCK = 0.
  - Reset mid-transfer aborts immediately and does not wait for HREADY.
- Address mux (combinational): HADDR/HTRANS/HWRITE/HSIZE/HBURST select master HMASTER.
- Data mux: HWDATA selects HWDATA_M[DMASTER]. DMASTER <= HMASTER on every HCLK edge with HREADY=1, otherwise it holds.
- HMASTLOCK = HLOCK_M[HMASTER] (combinational).
- keep = HLOCK_M[HMASTER], or HTRANS_M[HMASTER] in {BUSY, SEQ}, or (HTRANS_M[HMASTER]=NONSEQ and HBURST_M[HMASTER]=INCR).
  - While keep=1, grant never changes, so bursts and locked sequences are never split.
- Boundary: HCLK edge with HREADY=1 and keep=0. HGRANT, HMASTER, state and counter change only at a boundary; HREADY=0 freezes all of them.
- Round-robin pick: first index with HBUSREQ=1, searching HMASTER+1, HMASTER+2, ... modulo NUM_MASTERS and ending at HMASTER itself.
- Hold counter:
  - Increments at each HREADY=1 edge where the owner issues NONSEQ with HBURST=0; saturates at MAX_HOLD.
  - Clears to 0 whenever HMASTER changes.
- States:
  - PARK: no requests; DEFAULT_MASTER owns.
    - Boundary with any HBUSREQ -> OWN, grant = pick.
    - Pick may equal DEFAULT_MASTER: HMASTER is unchanged and the counter is not cleared.
  - OWN: owner granted by request.
    - Boundary with no HBUSREQ -> PARK, grant = DEFAULT_MASTER.
    - Boundary with owner HBUSREQ=0 and others requesting -> grant = pick.
    - Boundary with owner requesting, counter = MAX_HOLD and another master requesting -> grant = pick (forced yield).
    - Otherwise the owner keeps the grant.
    - HLOCK_M[owner]=1 at an edge with HREADY=1 -> LOCKED.
  - LOCKED: no arbitration; counter frozen. HLOCK_M[owner]=0 at an HREADY=1 edge -> OWN; the next boundary arbitrates normally.
- Simultaneous requests at a boundary: round-robin order decides; no fixed priority.
- A new grant's first address phase appears the cycle after the boundary. The previous owner's last transfer completes in the data phase under DMASTER.
- HTRANS of non-granted masters is ignored; the slave side sees IDLE only when the owner drives IDLE.

Test Plan:
1. Reset, no requests -> HGRANT=3'b001, HMASTER=0, state PARK; HADDR follows master 0 while HBUSREQ=0.
2. M1 and M2 request at the same boundary, HMASTER=0 -> M1 granted next cycle; after M1 drops HBUSREQ and issues IDLE, M2 granted; HWDATA follows M1 for one more HREADY cycle.
3. M1 owns and issues NONSEQ INCR to 0x00 then SEQ to 0x01/0x02/0x03 while M2 requests -> M1 keeps grant for all 4 beats; M2 granted at the boundary after M1 issues IDLE.
4. M0 holds HBUSREQ and issues 4 NONSEQ singles, M2 requesting, MAX_HOLD=4 -> grant moves to M2 after the 4th transfer; counter reads 0 after the switch.
5. M1 asserts HLOCK_M with 6 NONSEQ singles while M0 and M2 request -> HMASTLOCK=1, no grant change until HLOCK_M drops; then M2 granted.
6. HREADY held low for 3 cycles during a grant-eligible boundary, then HRESTn pulsed low -> HGRANT, HMASTER and DMASTER frozen while HREADY is low; immediate return to DEFAULT_MASTER, PARK on reset.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with address/data multiplexing for NUM_MASTERS masters.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   PARK   | nobody requesting, DEFAULT_MASTER parked on the bus
//   OWN    | a requesting master owns the bus, normal arbitration
//   LOCKED | owner holds HLOCK, no arbitration and hold counter frozen
//
// Grant only moves at a boundary: an HREADY=1 edge where the owner is not in
// a burst (NONSEQ INCR, BUSY, SEQ) and not locked.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 4,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                     HCLK,
  input  logic                     HRESTn,
  input  logic                     HREADY,
  input  logic [NUM_MASTERS-1:0]   HBUSREQ,
  input  logic [NUM_MASTERS-1:0]   HLOCK_M,
  input  logic [2*NUM_MASTERS-1:0] HTRANS_M,
  input  logic [32*NUM_MASTERS-1:0] HADDR_M,
  input  logic [NUM_MASTERS-1:0]   HWRITE_M,
  input  logic [3*NUM_MASTERS-1:0] HSIZE_M,
  input  logic [NUM_MASTERS-1:0]   HBURST_M,
  input  logic [32*NUM_MASTERS-1:0] HWDATA_M,
  output logic [NUM_MASTERS-1:0]   HGRANT,
  output logic [MW-1:0]            HMASTER,
  output logic                     HMASTLOCK,
  output logic [31:0]              HADDR,
  output logic [1:0]               HTRANS,
  output logic                     HWRITE,
  output logic [2:0]               HSIZE,
  output logic                     HBURST,
  output logic [31:0]              HWDATA
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          dmaster_q;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [CW-1:0]          hold_cnt_q, hold_cnt_d;

  logic [1:0]  trans_a [NUM_MASTERS];
  logic [31:0] addr_a  [NUM_MASTERS];
  logic [2:0]  size_a  [NUM_MASTERS];
  logic [31:0] wdata_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign trans_a[g] = HTRANS_M[2*g +: 2];
    assign addr_a[g]  = HADDR_M[32*g +: 32];
    assign size_a[g]  = HSIZE_M[3*g +: 3];
    assign wdata_a[g] = HWDATA_M[32*g +: 32];
  end

  logic [1:0]    own_trans;
  logic          own_lock, own_burst, own_req, others_req, keep, boundary;
  logic [MW-1:0] pick, cand;
  logic          found;

  assign own_trans  = trans_a[hmaster_q];
  assign own_lock   = HLOCK_M[hmaster_q];
  assign own_burst  = HBURST_M[hmaster_q];
  assign own_req    = |(HBUSREQ & hgrant_q);
  assign others_req = |(HBUSREQ & ~hgrant_q);
  assign keep       = own_lock || (own_trans == TR_BUSY) || (own_trans == TR_SEQ) ||
                      ((own_trans == TR_NONSEQ) && own_burst);
  assign boundary   = HREADY && !keep;

  // Round-robin search starting just after the current owner, ending on it.
  always_comb begin
    pick  = hmaster_q;
    cand  = hmaster_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = MW'((int'(hmaster_q) + k) % NUM_MASTERS);
      if (!found && HBUSREQ[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state, next owner and hold-counter update.
  always_comb begin
    state_d    = state_q;
    hmaster_d  = hmaster_q;
    hold_cnt_d = hold_cnt_q;
    hgrant_d   = '0;
    unique case (state_q)
      PARK: begin
        if (boundary && (|HBUSREQ)) begin
          state_d   = OWN;
          hmaster_d = pick;
        end
      end
      OWN: begin
        if (HREADY && own_lock) begin
          state_d = LOCKED;
        end else if (boundary) begin
          if (!(|HBUSREQ)) begin
            state_d   = PARK;
            hmaster_d = DEF_IDX;
          end else if (!own_req) begin
            hmaster_d = pick;
          end else if ((hold_cnt_q == HOLD_MAX) && others_req) begin
            hmaster_d = pick;
          end
        end
      end
      LOCKED: begin
        if (HREADY && !own_lock) state_d = OWN;
      end
      default: state_d = PARK;
    endcase
    if (hmaster_d != hmaster_q) begin
      hold_cnt_d = '0;
    end else if (boundary && (state_q != LOCKED) && (own_trans == TR_NONSEQ) &&
                 !own_burst && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    for (int i = 0; i < NUM_MASTERS; i++) hgrant_d[i] = (hmaster_d == MW'(i));
  end

  // Arbitration state; next values equal current ones whenever HREADY is low.
  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      state_q    <= PARK;
      hmaster_q  <= DEF_IDX;
      hgrant_q   <= DEF_GRANT;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hmaster_q  <= hmaster_d;
      hgrant_q   <= hgrant_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Data-phase owner trails the address-phase owner by one completed transfer.
  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn)     dmaster_q <= DEF_IDX;
    else if (HREADY) dmaster_q <= hmaster_q;
  end

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = own_lock;
  assign HADDR     = addr_a[hmaster_q];
  assign HTRANS    = own_trans;
  assign HWRITE    = HWRITE_M[hmaster_q];
  assign HSIZE     = size_a[hmaster_q];
  assign HBURST    = own_burst;
  assign HWDATA    = wdata_a[dmaster_q];

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scenario bench for ahb_bus_arbiter (3 masters, default 0, hold limit 4).
module tb_ahb_bus_arbiter;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESTn, HREADY;
  logic [2:0]  HBUSREQ, HLOCK_M, HWRITE_M, HBURST_M;
  logic [5:0]  HTRANS_M;
  logic [95:0] HADDR_M, HWDATA_M;
  logic [8:0]  HSIZE_M;
  logic [2:0]  HGRANT;
  logic [1:0]  HMASTER;
  logic        HMASTLOCK;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HBURST;
  logic [2:0]  HSIZE;

  ahb_bus_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .MAX_HOLD(4)) u_dut (
    .HCLK(HCLK), .HRESTn(HRESTn), .HREADY(HREADY), .HBUSREQ(HBUSREQ),
    .HLOCK_M(HLOCK_M), .HTRANS_M(HTRANS_M), .HADDR_M(HADDR_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M), .HWDATA_M(HWDATA_M), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic       rdy;
    logic [2:0] req;
    logic [2:0] lock;
    logic [5:0] trans;
    logic [2:0] burst;
    int         m;
    int         dm;
  } row_t;

  typedef struct {
    int m;
    int dm;
  } exp_t;

  exp_t sb[$];
  row_t rows[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic row_t mk(logic rdy, logic [2:0] req, logic [2:0] lock,
                              logic [5:0] trans, logic [2:0] burst, int m, int dm);
    row_t r;
    r.rdy = rdy; r.req = req; r.lock = lock; r.trans = trans;
    r.burst = burst; r.m = m; r.dm = dm;
    return r;
  endfunction

  function automatic logic [31:0] wd(int m);
    return 32'hD000_0000 + 32'(m);
  endfunction

  function automatic logic [31:0] ad(int m, int beat);
    return 32'hA000_0000 + (32'(m) << 16) + 32'(beat);
  endfunction

  task automatic apply(row_t r, int beat);
    HREADY   = r.rdy;
    HBUSREQ  = r.req;
    HLOCK_M  = r.lock;
    HTRANS_M = r.trans;
    HBURST_M = r.burst;
    HADDR_M  = {ad(2, beat), ad(1, beat), ad(0, beat)};
  endtask

  task automatic test_reset();
    exp_t e;
    HRESTn = 1'b0; HREADY = 1'b1; HBUSREQ = '0; HLOCK_M = '0; HTRANS_M = '0;
    HBURST_M = '0; HWRITE_M = 3'b101; HSIZE_M = {3'd2, 3'd1, 3'd0};
    HWDATA_M = {wd(2), wd(1), wd(0)}; HADDR_M = {ad(2, 0), ad(1, 0), ad(0, 0)};
    #12;
    n_cmp++; if (HGRANT !== 3'b001) begin n_err++; $display("FAIL reset_grant got %b want 001", HGRANT); end
    n_cmp++; if (HMASTER !== 2'd0) begin n_err++; $display("FAIL reset_master got %0d want 0", HMASTER); end
    n_cmp++; if (u_dut.state_q !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0 (PARK)", u_dut.state_q); end
    n_cmp++; if (u_dut.hold_cnt_q !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", u_dut.hold_cnt_q); end
    n_cmp++; if (HMASTLOCK !== 1'b0) begin n_err++; $display("FAIL reset_lock got %b want 0", HMASTLOCK); end
    @(negedge HCLK); HRESTn = 1'b1;
    @(posedge HCLK); #1;
    rows.delete();
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 0));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i], i);
      sb.push_back('{rows[i].m, rows[i].dm});
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_cmp++; if (HMASTER !== 2'(e.m)) begin n_err++; $display("FAIL park[%0d] HMASTER got %0d want %0d", i, HMASTER, e.m); end
    end
    HADDR_M[31:0] = 32'h1234_5678; #1;
    n_cmp++; if (HADDR !== 32'h1234_5678) begin n_err++; $display("FAIL park_haddr got %h want 12345678", HADDR); end
    HADDR_M[31:0] = 32'hCAFE_0004; #1;
    n_cmp++; if (HADDR !== 32'hCAFE_0004) begin n_err++; $display("FAIL park_haddr2 got %h want cafe0004", HADDR); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_round_robin();
    exp_t e;
    rows.delete();
    rows.push_back(mk(1, 3'b110, 3'b000, {I, I, I}, 3'b000, 1, 0));
    rows.push_back(mk(1, 3'b110, 3'b000, {I, N, I}, 3'b000, 1, 1));
    rows.push_back(mk(1, 3'b100, 3'b000, {I, I, I}, 3'b000, 2, 1));
    rows.push_back(mk(1, 3'b100, 3'b000, {I, I, I}, 3'b000, 2, 2));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 2));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i], i);
      sb.push_back('{rows[i].m, rows[i].dm});
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_cmp++; if (HMASTER !== 2'(e.m)) begin n_err++; $display("FAIL rr[%0d] HMASTER got %0d want %0d", i, HMASTER, e.m); end
      n_cmp++; if (HGRANT !== (3'b001 << e.m)) begin n_err++; $display("FAIL rr[%0d] HGRANT got %b want %b", i, HGRANT, 3'b001 << e.m); end
      n_cmp++; if (HWDATA !== wd(e.dm)) begin n_err++; $display("FAIL rr[%0d] HWDATA got %h want %h", i, HWDATA, wd(e.dm)); end
    end
  endtask

  task automatic test_burst();
    exp_t e;
    rows.delete();
    rows.push_back(mk(1, 3'b010, 3'b000, {I, I, I}, 3'b000, 1, 0));
    rows.push_back(mk(1, 3'b100, 3'b000, {I, N, I}, 3'b010, 1, 1));
    rows.push_back(mk(1, 3'b100, 3'b000, {I, S, I}, 3'b010, 1, 1));
    rows.push_back(mk(1, 3'b100, 3'b000, {I, S, I}, 3'b010, 1, 1));
    rows.push_back(mk(1, 3'b100, 3'b000, {I, S, I}, 3'b010, 1, 1));
    rows.push_back(mk(1, 3'b100, 3'b000, {I, I, I}, 3'b000, 2, 1));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 2));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i], i - 1);
      if (rows[i].trans[3:2] != I) begin
        #1;
        n_cmp++; if (HADDR !== ad(1, i - 1)) begin n_err++; $display("FAIL burst[%0d] HADDR got %h want %h", i, HADDR, ad(1, i - 1)); end
        n_cmp++; if (HTRANS !== rows[i].trans[3:2] || HBURST !== 1'b1 || HSIZE !== 3'd1 || HWRITE !== 1'b0) begin
          n_err++; $display("FAIL burst[%0d] ctrl got %b/%b/%0d/%b want %b/1/1/0", i, HTRANS, HBURST, HSIZE, HWRITE, rows[i].trans[3:2]);
        end
      end
      sb.push_back('{rows[i].m, rows[i].dm});
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_cmp++; if (HMASTER !== 2'(e.m)) begin n_err++; $display("FAIL burst[%0d] HMASTER got %0d want %0d", i, HMASTER, e.m); end
      n_cmp++; if (HWDATA !== wd(e.dm)) begin n_err++; $display("FAIL burst[%0d] HWDATA got %h want %h", i, HWDATA, wd(e.dm)); end
    end
  endtask

  task automatic test_hold_limit();
    exp_t e;
    rows.delete();
    rows.push_back(mk(1, 3'b001, 3'b000, {I, I, I}, 3'b000, 0, 0));
    for (int k = 0; k < 4; k++) rows.push_back(mk(1, 3'b101, 3'b000, {I, I, N}, 3'b000, 0, 0));
    rows.push_back(mk(1, 3'b101, 3'b000, {I, I, I}, 3'b000, 2, 0));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 2));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i], i);
      sb.push_back('{rows[i].m, rows[i].dm});
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_cmp++; if (HMASTER !== 2'(e.m)) begin n_err++; $display("FAIL hold[%0d] HMASTER got %0d want %0d", i, HMASTER, e.m); end
      n_cmp++; if (HWDATA !== wd(e.dm)) begin n_err++; $display("FAIL hold[%0d] HWDATA got %h want %h", i, HWDATA, wd(e.dm)); end
      if (i == 0) begin
        n_cmp++; if (u_dut.state_q !== 2'd1) begin n_err++; $display("FAIL hold_own state got %0d want 1 (OWN)", u_dut.state_q); end
      end
      if (i == 4) begin
        n_cmp++; if (u_dut.hold_cnt_q !== 3'd4) begin n_err++; $display("FAIL hold_cnt4 got %0d want 4", u_dut.hold_cnt_q); end
      end
      if (i == 5) begin
        n_cmp++; if (u_dut.hold_cnt_q !== 3'd0) begin n_err++; $display("FAIL hold_cnt_clr got %0d want 0", u_dut.hold_cnt_q); end
      end
    end
  endtask

  task automatic test_locked();
    exp_t e;
    rows.delete();
    rows.push_back(mk(1, 3'b010, 3'b000, {I, I, I}, 3'b000, 1, 0));
    for (int k = 0; k < 6; k++) rows.push_back(mk(1, 3'b111, 3'b010, {I, N, I}, 3'b000, 1, 1));
    rows.push_back(mk(1, 3'b101, 3'b000, {I, I, I}, 3'b000, 1, 1));
    rows.push_back(mk(1, 3'b101, 3'b000, {I, I, I}, 3'b000, 2, 1));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 2));
    rows.push_back(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i], i);
      #1;
      n_cmp++; if (HMASTLOCK !== (|rows[i].lock)) begin n_err++; $display("FAIL lock[%0d] HMASTLOCK got %b want %b", i, HMASTLOCK, |rows[i].lock); end
      sb.push_back('{rows[i].m, rows[i].dm});
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_cmp++; if (HMASTER !== 2'(e.m)) begin n_err++; $display("FAIL lock[%0d] HMASTER got %0d want %0d", i, HMASTER, e.m); end
      n_cmp++; if (HWDATA !== wd(e.dm)) begin n_err++; $display("FAIL lock[%0d] HWDATA got %h want %h", i, HWDATA, wd(e.dm)); end
    end
  endtask

  task automatic test_ready_and_reset();
    exp_t e;
    rows.delete();
    rows.push_back(mk(1, 3'b100, 3'b000, {I, I, I}, 3'b000, 2, 0));
    for (int k = 0; k < 3; k++) rows.push_back(mk(0, 3'b010, 3'b000, {I, I, I}, 3'b000, 2, 0));
    rows.push_back(mk(1, 3'b010, 3'b000, {I, I, I}, 3'b000, 1, 2));
    rows.push_back(mk(1, 3'b010, 3'b010, {I, N, I}, 3'b010, 1, 1));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i], i);
      sb.push_back('{rows[i].m, rows[i].dm});
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_cmp++; if (HMASTER !== 2'(e.m)) begin n_err++; $display("FAIL rdy[%0d] HMASTER got %0d want %0d", i, HMASTER, e.m); end
      n_cmp++; if (HGRANT !== (3'b001 << e.m)) begin n_err++; $display("FAIL rdy[%0d] HGRANT got %b want %b", i, HGRANT, 3'b001 << e.m); end
      n_cmp++; if (HWDATA !== wd(e.dm)) begin n_err++; $display("FAIL rdy[%0d] HWDATA got %h want %h", i, HWDATA, wd(e.dm)); end
    end
    n_cmp++; if (HMASTLOCK !== 1'b1) begin n_err++; $display("FAIL prereset_lock got %b want 1", HMASTLOCK); end
    HREADY = 1'b0;
    #2;
    HRESTn = 1'b0;
    #1;
    n_cmp++; if (HMASTER !== 2'd0 || HGRANT !== 3'b001) begin n_err++; $display("FAIL async_reset got %0d/%b want 0/001", HMASTER, HGRANT); end
    n_cmp++; if (HWDATA !== wd(0)) begin n_err++; $display("FAIL async_reset HWDATA got %h want %h", HWDATA, wd(0)); end
    n_cmp++; if (u_dut.state_q !== 2'd0) begin n_err++; $display("FAIL async_reset state got %0d want 0 (PARK)", u_dut.state_q); end
    n_cmp++; if (HMASTLOCK !== 1'b0) begin n_err++; $display("FAIL async_reset lock got %b want 0", HMASTLOCK); end
    @(negedge HCLK); HRESTn = 1'b1;
    @(posedge HCLK); #1;
    apply(mk(1, 3'b000, 3'b000, {I, I, I}, 3'b000, 0, 0), 0);
    sb.push_back('{0, 0});
    @(posedge HCLK); #1;
    e = sb.pop_front();
    n_cmp++; if (HMASTER !== 2'(e.m) || HWDATA !== wd(e.dm)) begin n_err++; $display("FAIL post_reset got %0d/%h want %0d/%h", HMASTER, HWDATA, e.m, wd(e.dm)); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_hold_limit();
    test_locked();
    test_ready_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
